// File: rtl/mkds_chan_ctrl_if.sv
// Host-side bus of the MKDS channel controller.
// Handshake: CS is the only qualifier and acts as "valid"; there is no
// "ready" because the controller consumes exactly one data_in word on every
// CLK rising edge where CS=1. A frame is a run of consecutive CS=1 cycles:
// the first word is the command, the rest are payload words.
interface mkds_chan_ctrl_if #(
  parameter int N_CH   = 16,
  parameter int DATA_W = 8
);
  logic                     CS;
  logic [15:0]              data_in;
  logic [N_CH*DATA_W-1:0]   data_out;
  logic [N_CH-1:0]          strobe;
  logic [N_CH-1:0]          OE;
  logic [N_CH-1:0]          dir;
  logic                     busy;
  logic                     err;
  logic                     wdt_trip;

  // Host side: drives frames, observes the channel state.
  modport master (
    output CS, data_in,
    input  data_out, strobe, OE, dir, busy, err, wdt_trip
  );

  // Controller side.
  modport slave (
    input  CS, data_in,
    output data_out, strobe, OE, dir, busy, err, wdt_trip
  );
endinterface

// File: rtl/mkds_chan_ctrl.sv
// MKDS channel control/register block.
// Decodes CS-framed command/payload words into per-channel data registers
// (auto-incrementing burst writes with a one-cycle write strobe), OE and dir
// masks written 16 bits per payload word, a sticky range-error flag, and an
// optional watchdog that drops OE when the host stops sending frames.
// busy is a direct decode of the FSM state (high in PAYLOAD).
module mkds_chan_ctrl #(
  parameter int N_CH       = 16,
  parameter int DATA_W     = 8,
  parameter int WDT_CYCLES = 0
) (
  input  logic            CLK,
  input  logic            RST,
  mkds_chan_ctrl_if.slave bus
);

  localparam int N_MW    = (N_CH + 15) / 16;   // 16-bit mask words per mask
  localparam int MW_BITS = N_MW * 16;
  localparam int DW      = N_CH * DATA_W;
  localparam logic [7:0] N_CH_B = 8'(N_CH);
  localparam logic [7:0] N_MW_B = 8'(N_MW);
  localparam int WDT_W = (WDT_CYCLES > 0) ? $clog2(WDT_CYCLES + 1) : 1;
  localparam logic [WDT_W-1:0] WDT_FULL = (WDT_CYCLES > 0) ? WDT_W'(WDT_CYCLES) : '0;
  localparam logic [WDT_W-1:0] WDT_LAST = (WDT_CYCLES > 0) ? WDT_W'(WDT_CYCLES - 1) : '0;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PAYLOAD = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_DATA = 2'b00,
    OP_OE   = 2'b01,
    OP_DIR  = 2'b10,
    OP_NOP  = 2'b11
  } op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [7:0]         addr_q, addr_d;
  logic [DW-1:0]      data_q, data_d;
  logic [N_CH-1:0]    strobe_q, strobe_d;
  logic [N_CH-1:0]    oe_q, oe_d;
  logic [N_CH-1:0]    dir_q, dir_d;
  logic               err_q, err_d;
  logic               trip_q, trip_d;
  logic [WDT_W-1:0]   wdt_q, wdt_d;

  // Scratch vector: the current mask padded to whole 16-bit words so a
  // payload word can be dropped in at any legal word index.
  logic [MW_BITS-1:0] mask_pad;
  logic               unused_bits;

  // Next-state, register writes, error flag and watchdog.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    strobe_d = '0;
    oe_d     = oe_q;
    dir_d    = dir_q;
    err_d    = err_q;
    trip_d   = trip_q;
    wdt_d    = wdt_q;
    mask_pad = '0;

    // Watchdog first so that an OE write later in this block overrides a
    // trip on the same edge. Any CS=1 cycle and the frame-end cycle (the
    // only CS=0 cycle spent in PAYLOAD) restart the count.
    if (WDT_CYCLES > 0) begin
      if (bus.CS || state_q == S_PAYLOAD) begin
        wdt_d = '0;
      end else if (wdt_q != WDT_FULL) begin
        wdt_d = wdt_q + WDT_W'(1);
        if (wdt_q == WDT_LAST) begin
          oe_d   = '0;
          trip_d = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.CS) begin
          op_d    = op_t'(bus.data_in[15:14]);
          addr_d  = bus.data_in[7:0];
          state_d = S_PAYLOAD;
          if (bus.data_in[15:14] == OP_NOP && bus.data_in[8]) begin
            err_d = 1'b0;
          end
        end
      end

      S_PAYLOAD: begin
        if (bus.CS) begin
          // Saturate so an overrun burst keeps flagging errors instead of
          // wrapping back onto channel 0.
          addr_d = (addr_q == 8'hFF) ? 8'hFF : addr_q + 8'd1;
          case (op_q)
            OP_DATA: begin
              if (addr_q < N_CH_B) begin
                for (int i = 0; i < N_CH; i++) begin
                  if (addr_q == 8'(i)) begin
                    data_d[i*DATA_W +: DATA_W] = bus.data_in[DATA_W-1:0];
                    strobe_d[i]                = 1'b1;
                  end
                end
              end else begin
                err_d = 1'b1;
              end
            end

            OP_OE, OP_DIR: begin
              if (addr_q < N_MW_B) begin
                mask_pad[N_CH-1:0] = (op_q == OP_OE) ? oe_q : dir_q;
                for (int w = 0; w < N_MW; w++) begin
                  if (addr_q == 8'(w)) begin
                    mask_pad[w*16 +: 16] = bus.data_in;
                  end
                end
                if (op_q == OP_OE) begin
                  oe_d   = mask_pad[N_CH-1:0];
                  trip_d = 1'b0;
                end else begin
                  dir_d  = mask_pad[N_CH-1:0];
                end
              end else begin
                err_d = 1'b1;
              end
            end

            default: begin
              // NOP/kick payload words are accepted and ignored.
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Reserved command bits and mask bits beyond N_CH carry no state.
  assign unused_bits = ^{bus.data_in[13:9], mask_pad};

  // State and register file, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      op_q     <= OP_DATA;
      addr_q   <= 8'd0;
      data_q   <= '0;
      strobe_q <= '0;
      oe_q     <= '0;
      dir_q    <= '0;
      err_q    <= 1'b0;
      trip_q   <= 1'b0;
      wdt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      oe_q     <= oe_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      trip_q   <= trip_d;
      wdt_q    <= wdt_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.strobe   = strobe_q;
  assign bus.OE       = oe_q;
  assign bus.dir      = dir_q;
  assign bus.busy     = (state_q == S_PAYLOAD);
  assign bus.err      = err_q;
  assign bus.wdt_trip = trip_q;

endmodule

// File: tb/tb_mkds_chan_ctrl.sv
// Bench for mkds_chan_ctrl: three instances cover the 16-channel burst/range
// cases, the 24-channel mask cases and the watchdog.
module tb_mkds_chan_ctrl;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mkds_chan_ctrl_if #(.N_CH(16), .DATA_W(8)) if_a ();
  mkds_chan_ctrl_if #(.N_CH(24), .DATA_W(8)) if_b ();
  mkds_chan_ctrl_if #(.N_CH(16), .DATA_W(8)) if_c ();

  mkds_chan_ctrl #(.N_CH(16), .DATA_W(8), .WDT_CYCLES(0)) dut_a (
    .CLK(CLK), .RST(RST), .bus(if_a.slave));
  mkds_chan_ctrl #(.N_CH(24), .DATA_W(8), .WDT_CYCLES(0)) dut_b (
    .CLK(CLK), .RST(RST), .bus(if_b.slave));
  mkds_chan_ctrl #(.N_CH(16), .DATA_W(8), .WDT_CYCLES(10)) dut_c (
    .CLK(CLK), .RST(RST), .bus(if_c.slave));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // OR-reduction of every output of every instance, one bit per output.
  task automatic check_all_zero(input string name);
    logic [23:0] v;
    v = {|if_a.data_out, |if_a.strobe, |if_a.OE, |if_a.dir, if_a.busy, if_a.err, if_a.wdt_trip, 1'b0,
         |if_b.data_out, |if_b.strobe, |if_b.OE, |if_b.dir, if_b.busy, if_b.err, if_b.wdt_trip, 1'b0,
         |if_c.data_out, |if_c.strobe, |if_c.OE, |if_c.dir, if_c.busy, if_c.err, if_c.wdt_trip, 1'b0};
    check(name, 64'(v), 64'd0);
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are read 1 time
  // unit after the next rising edge, i.e. right after the sampling edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int d, input logic cs, input logic [15:0] w);
    case (d)
      0: begin if_a.CS = cs; if_a.data_in = w; end
      1: begin if_b.CS = cs; if_b.data_in = w; end
      default: begin if_c.CS = cs; if_c.data_in = w; end
    endcase
    tick();
  endtask

  // ---------------- vector table (instance a, N_CH=16) ----------------
  typedef struct {
    logic        cs;
    logic [15:0] din;
    int          ch;
    logic [7:0]  exp_data;
    logic [15:0] exp_strobe;
    logic        exp_busy;
    logic        exp_err;
  } vec_t;

  localparam int N_VEC = 24;
  vec_t vecs [N_VEC];

  initial begin
    // burst write ch3..5
    vecs[0]  = '{1'b1, 16'h0003,  3, 8'h00, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 16'h00A1,  3, 8'hA1, 16'h0008, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 16'h00B2,  4, 8'hB2, 16'h0010, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 16'h00C3,  5, 8'hC3, 16'h0020, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000,  3, 8'hA1, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000,  4, 8'hB2, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000,  5, 8'hC3, 16'h0000, 1'b0, 1'b0};
    // range error at ch16, then clear with NOP clr
    vecs[7]  = '{1'b1, 16'h000F, 15, 8'h00, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 16'h0011, 15, 8'h11, 16'h8000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'h0022, 15, 8'h11, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 16'h0000,  0, 8'h00, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 16'hC100, 15, 8'h11, 16'h0000, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 15, 8'h11, 16'h0000, 1'b0, 1'b0};
    // single-cycle CS: command only, no write
    vecs[13] = '{1'b1, 16'h0007,  7, 8'h00, 16'h0000, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 16'h0000,  7, 8'h00, 16'h0000, 1'b0, 1'b0};
    // NOP frame with payload: ignored, no error
    vecs[15] = '{1'b1, 16'hC000,  5, 8'hC3, 16'h0000, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 16'h0055,  0, 8'h00, 16'h0000, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 16'h0000,  0, 8'h00, 16'h0000, 1'b0, 1'b0};
    // address 255: counter saturates, never wraps onto ch0
    vecs[18] = '{1'b1, 16'h00FF,  0, 8'h00, 16'h0000, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 16'h0011,  0, 8'h00, 16'h0000, 1'b1, 1'b1};
    vecs[20] = '{1'b1, 16'h0022,  0, 8'h00, 16'h0000, 1'b1, 1'b1};
    vecs[21] = '{1'b0, 16'h0000,  0, 8'h00, 16'h0000, 1'b0, 1'b1};
    vecs[22] = '{1'b1, 16'hC100,  0, 8'h00, 16'h0000, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 16'h0000,  3, 8'hA1, 16'h0000, 1'b0, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    if_a.CS = 1'b0; if_a.data_in = '0;
    if_b.CS = 1'b0; if_b.data_in = '0;
    if_c.CS = 1'b0; if_c.data_in = '0;
    RST = 1'b1;

    // Reset held with random bus activity.
    for (int i = 0; i < 4; i++) begin
      if_a.CS = 1'($urandom_range(0, 1)); if_a.data_in = 16'($urandom_range(0, 65535));
      if_b.CS = 1'($urandom_range(0, 1)); if_b.data_in = 16'($urandom_range(0, 65535));
      if_c.CS = 1'($urandom_range(0, 1)); if_c.data_in = 16'($urandom_range(0, 65535));
      tick();
      check_all_zero($sformatf("reset_hold%0d", i));
    end
    RST = 1'b0;
    if_a.CS = 1'b0; if_b.CS = 1'b0; if_c.CS = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all_zero($sformatf("after_reset%0d", i));
    end

    // Table-driven data path on instance a.
    for (int i = 0; i < N_VEC; i++) begin
      drive(0, vecs[i].cs, vecs[i].din);
      check($sformatf("vec%0d strobe", i), 64'(if_a.strobe), 64'(vecs[i].exp_strobe));
      check($sformatf("vec%0d busy", i), 64'(if_a.busy), 64'(vecs[i].exp_busy));
      check($sformatf("vec%0d err", i), 64'(if_a.err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d ch%0d", i, vecs[i].ch),
            64'(if_a.data_out[vecs[i].ch*8 +: 8]), 64'(vecs[i].exp_data));
    end

    // Mask writes on instance b (N_CH=24).
    drive(1, 1'b1, 16'h4000);
    drive(1, 1'b1, 16'hFFFF);
    drive(1, 1'b1, 16'h00F0);
    drive(1, 1'b0, 16'h0000);
    check("b_oe", 64'(if_b.OE), 64'h00F0FFFF);
    check("b_err_oe", 64'(if_b.err), 64'd0);
    drive(1, 1'b1, 16'h8001);
    drive(1, 1'b1, 16'h1234);
    drive(1, 1'b0, 16'h0000);
    check("b_dir", 64'(if_b.dir), 64'h00340000);
    check("b_oe_kept", 64'(if_b.OE), 64'h00F0FFFF);
    check("b_err_dir", 64'(if_b.err), 64'd0);
    drive(1, 1'b1, 16'h8002);
    drive(1, 1'b1, 16'h0001);
    check("b_err_range", 64'(if_b.err), 64'd1);
    check("b_dir_kept", 64'(if_b.dir), 64'h00340000);
    drive(1, 1'b0, 16'h0000);

    // Watchdog on instance c (WDT_CYCLES=10).
    drive(2, 1'b1, 16'h8000);
    drive(2, 1'b1, 16'h00AA);
    drive(2, 1'b0, 16'h0000);
    drive(2, 1'b1, 16'h4000);
    drive(2, 1'b1, 16'h00FF);
    check("c_oe_written", 64'(if_c.OE), 64'h00FF);
    check("c_trip_cleared", 64'(if_c.wdt_trip), 64'd0);
    drive(2, 1'b0, 16'h0000);          // frame end restarts the count
    for (int i = 0; i < 9; i++) drive(2, 1'b0, 16'h0000);
    check("c_oe_before_trip", 64'(if_c.OE), 64'h00FF);
    check("c_no_trip_yet", 64'(if_c.wdt_trip), 64'd0);
    drive(2, 1'b0, 16'h0000);
    check("c_oe_tripped", 64'(if_c.OE), 64'd0);
    check("c_trip", 64'(if_c.wdt_trip), 64'd1);
    check("c_dir_untouched", 64'(if_c.dir), 64'h00AA);
    drive(2, 1'b1, 16'hC000);
    drive(2, 1'b0, 16'h0000);
    check("c_kick_oe", 64'(if_c.OE), 64'd0);
    check("c_kick_trip", 64'(if_c.wdt_trip), 64'd1);
    drive(2, 1'b1, 16'h4000);
    drive(2, 1'b1, 16'h000F);
    check("c_oe_restored", 64'(if_c.OE), 64'h000F);
    check("c_trip_restored", 64'(if_c.wdt_trip), 64'd0);
    drive(2, 1'b0, 16'h0000);

    // Reset in the middle of a 4-word burst on instance a.
    drive(0, 1'b1, 16'h0000);
    drive(0, 1'b1, 16'h0011);
    drive(0, 1'b1, 16'h0022);
    check("mid_ch1", 64'(if_a.data_out[15:8]), 64'h22);
    check("mid_strobe", 64'(if_a.strobe), 64'h0002);
    #2;
    if_a.data_in = 16'h0033;
    RST = 1'b1;
    #1;
    check("mid_rst_data", 64'(|if_a.data_out), 64'd0);
    check("mid_rst_strobe", 64'(if_a.strobe), 64'd0);
    check("mid_rst_busy", 64'(if_a.busy), 64'd0);
    check("mid_rst_b_oe", 64'(if_b.OE), 64'd0);
    tick();
    #2;
    RST = 1'b0;
    if_a.CS = 1'b1;
    if_a.data_in = 16'h0004;
    tick();
    check("post_rst_busy", 64'(if_a.busy), 64'd1);
    check("post_rst_strobe", 64'(if_a.strobe), 64'd0);
    check("post_rst_ch4", 64'(if_a.data_out[39:32]), 64'd0);
    drive(0, 1'b1, 16'h0099);
    check("post_rst_ch4_write", 64'(if_a.data_out[39:32]), 64'h99);
    check("post_rst_strobe4", 64'(if_a.strobe), 64'h0010);
    drive(0, 1'b0, 16'h0000);
    check("post_rst_idle", 64'(if_a.busy), 64'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
